// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/RAM types, plus the arbiter state encoding.
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder, first active index at or after ptr.
`default_nettype none

module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] active,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            valid
);

    logic [2*NREQ-1:0] doubled;
    logic [2*NREQ-1:0] rotated;
    logic [IW:0]       sum;

    assign doubled = {active, active};
    assign rotated = doubled >> ptr;

    // Scan from the far end so the nearest active slot after ptr is the last writer.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = {1'b0, ptr} + (IW + 1)'(k);
                if (sum >= (IW + 1)'(NREQ)) begin
                    sum = sum - (IW + 1)'(NREQ);
                end
                grant = sum[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter locking one requester onto the RAM port until ACCESS.
`default_nettype none

module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NREQ-1:0]     req_ren,
    input  logic [NREQ-1:0]     req_wen,
    input  word_t [NREQ-1:0]    req_addr,
    input  word_t [NREQ-1:0]    req_store,
    output logic [NREQ-1:0]     req_wait,
    output word_t               req_load,
    output logic                memREN,
    output logic                memWEN,
    output word_t               memaddr,
    output word_t               memstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [NREQ-1:0] active;

    assign active   = req_ren | req_wen;
    assign req_load = ramload;
    assign next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .active (active),
        .ptr    (rr_ptr),
        .grant  (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        state <= OWN;
                    end
                end
                OWN: begin
                    // Only a completed access moves the pointer; an abort leaves it alone.
                    if (ramstate == ACCESS) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (!active[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        memREN   = 1'b0;
        memWEN   = 1'b0;
        memaddr  = '0;
        memstore = '0;
        if (state == OWN) begin
            memWEN   = req_wen[owner];
            memREN   = req_ren[owner] & ~req_wen[owner];
            memaddr  = req_addr[owner];
            memstore = req_store[owner];
        end
    end

    always_comb begin
        req_wait = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_wait[i] = active[i] &
                          ~((state == OWN) && (owner == IW'(i)) && (ramstate == ACCESS));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks plus randomized traffic against a behavioural arbiter model.
`default_nettype none

module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int N = 2;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic [N-1:0]    req_ren, req_wen, req_wait;
    word_t [N-1:0]   req_addr, req_store;
    word_t           req_load, memaddr, memstore, ramload;
    logic            memREN, memWEN;
    ramstate_t       ramstate;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_arbiter #(.NREQ(N)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .memREN    (memREN),
        .memWEN    (memWEN),
        .memaddr   (memaddr),
        .memstore  (memstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the RAM, and where the next search starts.
    bit m_own;
    int m_owner;
    int m_ptr;

    function automatic bit act_of(int i);
        return req_ren[i] | req_wen[i];
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (act_of((m_ptr + k) % N)) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_wait();
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) begin
            w[i] = act_of(i) && !(m_own && m_owner == i && ramstate == ACCESS);
        end
        return w;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_own   <= 1'b0;
            m_owner <= 0;
            m_ptr   <= 0;
        end else if (!m_own) begin
            if (pick() >= 0) begin
                m_own   <= 1'b1;
                m_owner <= pick();
            end
        end else if (ramstate == ACCESS) begin
            m_own <= 1'b0;
            m_ptr <= (m_owner + 1) % N;
        end else if (!act_of(m_owner)) begin
            m_own <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            chk("mon_memREN", 32'(memREN),
                32'(m_own && req_ren[m_owner] && !req_wen[m_owner]));
            chk("mon_memWEN", 32'(memWEN), 32'(m_own && req_wen[m_owner]));
            chk("mon_memaddr", memaddr, m_own ? req_addr[m_owner] : 32'h0);
            chk("mon_memstore", memstore, m_own ? req_store[m_owner] : 32'h0);
            chk("mon_req_wait", 32'(req_wait), 32'(exp_wait()));
            chk("mon_req_load", req_load, ramload);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    logic [N-1:0] served;
    logic [1:0]   r;
    int           own_exp;

    initial begin
        req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
        ramload = '0; ramstate = FREE;

        #3;
        chk("rst_memREN", 32'(memREN), 32'h0);
        chk("rst_memWEN", 32'(memWEN), 32'h0);
        chk("rst_memaddr", memaddr, 32'h0);
        chk("rst_wait", 32'(req_wait), 32'h0);
        req_ren = 2'b01;
        #1;
        chk("rst_wait_active", 32'(req_wait), 32'h1);
        chk("rst_memREN_active", 32'(memREN), 32'h0);
        req_ren = '0;
        step();
        step();
        nRST = 1'b1;

        // Single read with two BUSY cycles.
        req_ren = 2'b01; req_addr[0] = 32'h100; ramstate = BUSY;
        #3;
        chk("rd_c0_memREN", 32'(memREN), 32'h0);
        chk("rd_c0_wait", 32'(req_wait), 32'h1);
        for (int c = 1; c <= 2; c++) begin
            step(); #3;
            chk("rd_busy_memREN", 32'(memREN), 32'h1);
            chk("rd_busy_addr", memaddr, 32'h100);
            chk("rd_busy_wait", 32'(req_wait), 32'h1);
        end
        step();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #3;
        chk("rd_acc_wait", 32'(req_wait), 32'h0);
        chk("rd_acc_load", req_load, 32'hDEADBEEF);
        chk("rd_acc_memREN", 32'(memREN), 32'h1);
        step();
        req_ren = '0; ramstate = FREE;
        #3;
        chk("rd_after_memREN", 32'(memREN), 32'h0);

        // Both requesters held: grants alternate 0,1,0,1 with an idle bubble between.
        step();
        pulse_reset();
        step();
        req_ren = 2'b11; req_addr[0] = 32'h10; req_addr[1] = 32'h20; ramstate = ACCESS;
        #3;
        chk("rr_c0_memREN", 32'(memREN), 32'h0);
        chk("rr_c0_wait", 32'(req_wait), 32'h3);
        for (int c = 1; c <= 20; c++) begin
            step(); #3;
            if (c % 2 == 1) begin
                own_exp = ((c - 1) / 2) % 2;
                chk("rr_grant_memREN", 32'(memREN), 32'h1);
                chk("rr_grant_addr", memaddr, own_exp == 1 ? 32'h20 : 32'h10);
                chk("rr_grant_wait", 32'(req_wait), own_exp == 1 ? 32'h1 : 32'h2);
            end else begin
                chk("rr_bubble_memREN", 32'(memREN), 32'h0);
                chk("rr_bubble_wait", 32'(req_wait), 32'h3);
            end
        end
        req_ren = '0; ramstate = FREE;

        // Write wins over read; then reset mid-access drops enables at once.
        step();
        pulse_reset();
        step();
        req_ren = 2'b10; req_wen = 2'b10; req_addr[1] = 32'h200;
        req_store[1] = 32'h12345678; ramstate = BUSY;
        step(); #3;
        chk("wr_memWEN", 32'(memWEN), 32'h1);
        chk("wr_memREN", 32'(memREN), 32'h0);
        chk("wr_memstore", memstore, 32'h12345678);
        chk("wr_memaddr", memaddr, 32'h200);
        step();
        nRST = 1'b0;
        #1;
        chk("arst_memWEN", 32'(memWEN), 32'h0);
        chk("arst_memREN", 32'(memREN), 32'h0);
        step();
        nRST = 1'b1;
        #2;
        chk("arst_idle_memWEN", 32'(memWEN), 32'h0);
        chk("arst_idle_wait", 32'(req_wait), 32'h2);
        step(); #3;
        chk("arst_regrant_memWEN", 32'(memWEN), 32'h1);
        req_ren = '0; req_wen = '0; ramstate = FREE;

        // Owner aborts while BUSY: pending requester gets the RAM, pointer stays at 0.
        step();
        pulse_reset();
        step();
        req_ren = 2'b11; req_addr[0] = 32'h40; req_addr[1] = 32'h80; ramstate = BUSY;
        step(); #3;
        chk("ab_own0_addr", memaddr, 32'h40);
        chk("ab_own0_memREN", 32'(memREN), 32'h1);
        step();
        req_ren = 2'b10;
        #3;
        chk("ab_drop_memREN", 32'(memREN), 32'h0);
        chk("ab_drop_wait", 32'(req_wait), 32'h2);
        step(); #3;
        chk("ab_idle_memREN", 32'(memREN), 32'h0);
        step(); #3;
        chk("ab_own1_memREN", 32'(memREN), 32'h1);
        chk("ab_own1_addr", memaddr, 32'h80);
        step();
        req_ren = '0;
        step();
        req_ren = 2'b11;
        #3;
        chk("ab_idle2_memREN", 32'(memREN), 32'h0);
        step(); #3;
        chk("ab_ptr_kept_addr", memaddr, 32'h40);
        req_ren = '0; ramstate = FREE;

        // Randomized traffic checked by the monitor every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            served = (req_ren | req_wen) & ~exp_wait();
            step();
            for (int i = 0; i < N; i++) begin
                if (!act_of(i) || served[i]) begin
                    if ($urandom_range(0, 9) < 5) begin
                        r = 2'($urandom_range(1, 3));
                        req_ren[i]   = r[0];
                        req_wen[i]   = r[1];
                        req_addr[i]  = $urandom;
                        req_store[i] = $urandom;
                    end else begin
                        req_ren[i] = 1'b0;
                        req_wen[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_ren[i] = 1'b0;
                    req_wen[i] = 1'b0;
                end
            end
            ramstate = ramstate_t'($urandom_range(0, 3));
            ramload  = $urandom;
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the single `cpu_ram_if` RAM port between `NREQ` memory requesters, e.g. the two cores' caches under `multicore`. It sits between the requesters and the RAM-side signals (`memREN`, `memWEN`, `memaddr`, `memstore`) that feed the testbench-control mux in `system`. It locks one requester onto the RAM until the RAM reports `ACCESS`, then releases and re-arbitrates.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..4.

Ports:
- `CLK`  in  1  system clock; one clock domain.
- `nRST`  in  1  asynchronous, active-low reset.
- `req_ren`  in  `NREQ`  per-requester read request.
- `req_wen`  in  `NREQ`  per-requester write request.
- `req_addr`  in  `NREQ` x `word_t`  per-requester word address.
- `req_store`  in  `NREQ` x `word_t`  per-requester write data.
- `req_wait`  out  `NREQ`  per-requester stall; low means the access completes this cycle.
- `req_load`  out  `word_t`  read data, `ramload` broadcast to all requesters.
- `memREN`  out  1  RAM read enable.
- `memWEN`  out  1  RAM write enable.
- `memaddr`  out  `word_t`  RAM address.
- `memstore`  out  `word_t`  RAM write data.
- `ramload`  in  `word_t`  RAM read data.
- `ramstate`  in  `ramstate_t`  RAM status: FREE, BUSY, ACCESS, ERROR.

## Operation
- States: IDLE and OWN. In OWN, the register `owner` (width `$clog2(NREQ)`) selects the requester connected to the RAM.
- A requester is active when `req_ren[i] | req_wen[i]`.
- IDLE:
  - RAM outputs are all 0.
  - If any requester is active, pick the first active index searching upward from `rr_ptr`, wrapping at `NREQ`.
  - Latch that index into `owner` and go to OWN at the next edge.
- OWN, RAM side:
  - `memaddr` and `memstore` are muxed combinationally from `owner`.
  - `memWEN = req_wen[owner]`.
  - `memREN = req_ren[owner] & ~req_wen[owner]`: write wins if both are asserted.
- OWN, transitions:
  - `ramstate == ACCESS`: the access completes. Go to IDLE and set `rr_ptr = owner+1` mod `NREQ`.
  - Owner drops both REN and WEN (abort): go to IDLE. `rr_ptr` is unchanged.
  - BUSY, FREE or ERROR: stay in OWN and keep retrying.
- `req_wait[i]`:
  - 0 when requester `i` is inactive.
  - 0 when `i == owner`, state is OWN and `ramstate == ACCESS`.
  - 1 otherwise while active.
- `req_load = ramload` at all times. It is valid only in the owner's completing cycle.
- Owner address or data changing mid-access is not allowed. The arbiter passes it through unchecked.

## Timing
- Reset values:
  - Internal: state IDLE, `owner` 0, `rr_ptr` 0.
  - RAM outputs: `memREN`/`memWEN` 0, `memaddr`/`memstore` 0.
  - Requester side: `req_wait` = active mask (combinational), `req_load` = `ramload`.
- Grant latency: a request asserted in cycle n drives RAM signals from cycle n+1. The request is then served after RAM latency.
- Release costs one IDLE bubble cycle, so back-to-back accesses are separated by at least one cycle with RAM enables low.
- Simultaneous requests: the requester at or after `rr_ptr` wins, so the last-served requester has lowest priority and no requester starves.
- Reset asserted mid-access: state returns to IDLE immediately and RAM enables drop asynchronously. The aborted access is not retried by the arbiter.
- Single requester active: it is re-granted every other cycle. `rr_ptr` advancing does not block it.

## Structure
- `ramstate_t` and `word_t` come from `cpu_types_pkg`.
- Add `arb_state_t` (IDLE, OWN) to `cpu_types_pkg`.
- One natural sub-module: `rr_picker`, a combinational round-robin priority encoder taking the active mask and `rr_ptr` and returning the grant index and a valid bit.
- Target size: about 150 lines of RTL.

## Test plan
- After reset, idle: `memREN`/`memWEN` = 0, `req_wait` = 00.
- Requester 0 reads `0x100`, RAM BUSY 2 cycles then ACCESS with `ramload = 0xDEADBEEF`:
  - `memREN` = 1 and `memaddr = 0x100` from cycle 1.
  - `req_wait[0]` = 1 until the ACCESS cycle, where it is 0 and `req_load = 0xDEADBEEF`.
- Both requesters request in the same cycle after reset:
  - Requester 0 is served first, then requester 1.
  - Repeat: requester 1 now wins. Check alternation across 10 rounds.
- Requester 1 asserts REN and WEN at `0x200` with `store = 0x12345678`: `memWEN` = 1, `memREN` = 0, `memstore = 0x12345678`.
- Requester 0 drops its request while BUSY: state returns to IDLE, `rr_ptr` is unchanged, and a pending requester 1 is granted next.
- `nRST` asserted during OWN with RAM BUSY: `memWEN`/`memREN` drop in the same cycle and the state is IDLE after release.
